// File: rtl/csa_accum_pkg.sv
// ============================================================================
// csa_accum_pkg : shared state encodings and default sizing for csa_accum
// Revision      : 1.0
// ============================================================================
`default_nettype none

package csa_accum_pkg;

    localparam int DEF_WIDTH     = 13;
    localparam int DEF_MAX_TERMS = 16;

    localparam logic [1:0] ST_ACC = 2'd0;
    localparam logic [1:0] ST_RES = 2'd1;
    localparam logic [1:0] ST_OUT = 2'd2;

endpackage

`default_nettype wire

// File: rtl/csa_n.sv
// ============================================================================
// csa_n    : combinational carry-save row of W full adders (outputs unshifted)
// Revision : 1.0
// ============================================================================
`default_nettype none

module csa_n #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] carry_o
);

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum_o[i]   = a_i[i] ^ b_i[i] ^ c_i[i];
        assign carry_o[i] = (a_i[i] & b_i[i]) | (a_i[i] & c_i[i]) | (b_i[i] & c_i[i]);
    end

endmodule

`default_nettype wire

// File: rtl/csa_accum.sv
// ============================================================================
// csa_accum : streaming multi-operand accumulator, carry-save loop + one CPA
// Revision  : 1.0
// ============================================================================
`default_nettype none

module csa_accum
    import csa_accum_pkg::*;
#(
    parameter  int WIDTH     = DEF_WIDTH,
    parameter  int MAX_TERMS = DEF_MAX_TERMS,
    localparam int CNT_W     = $clog2(MAX_TERMS) + 1,
    localparam int ACC_W     = WIDTH + $clog2(MAX_TERMS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_trunc
);

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] s_q, s_d, c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trunc_q, trunc_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_trunc_q, out_trunc_d;

    logic [ACC_W-1:0] w_row_sum, w_row_carry;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_accept;
    logic             w_close;

    csa_n #(.W(ACC_W)) u_csa (
        .a_i     (s_q),
        .b_i     (c_q),
        .c_i     (ACC_W'(in_data)),
        .sum_o   (w_row_sum),
        .carry_o (w_row_carry)
    );

    assign w_accept  = in_valid && in_ready;
    assign w_cnt_inc = cnt_q + 1'b1;
    assign w_close   = in_last || (w_cnt_inc == CNT_W'(MAX_TERMS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC:  if (w_accept && w_close) state_d = ST_RES;
            ST_RES:  state_d = ST_OUT;
            ST_OUT:  if (out_ready) state_d = ST_ACC;
            default: state_d = ST_ACC;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ST_ACC);
    end

    // The carry MSB is always zero because ACC_W holds the full burst sum, so the shift loses nothing.
    always_comb begin
        s_d         = s_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        trunc_d     = trunc_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_trunc_d = out_trunc_q;
        case (state_q)
            ST_ACC: begin
                if (w_accept) begin
                    s_d   = w_row_sum;
                    c_d   = w_row_carry << 1;
                    cnt_d = w_cnt_inc;
                    if (w_close) trunc_d = ~in_last;
                end
            end
            ST_RES: begin
                out_sum_d   = s_q + c_q;
                out_count_d = cnt_q;
                out_trunc_d = trunc_q;
                out_valid_d = 1'b1;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    s_d         = '0;
                    c_d         = '0;
                    cnt_d       = '0;
                    trunc_d     = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q         <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            trunc_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_trunc_q <= 1'b0;
        end else begin
            s_q         <= s_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            trunc_q     <= trunc_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_trunc_q <= out_trunc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_trunc = out_trunc_q;

endmodule

`default_nettype wire

// File: tb/tb_csa_accum.sv
// ============================================================================
// tb_csa_accum : directed + randomised self-checking bench for csa_accum
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_csa_accum;

    localparam int WIDTH = 13;
    localparam int ACC_W = 17;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_trunc;

    int n_tests = 0;
    int n_fail  = 0;

    csa_accum #(.WIDTH(WIDTH), .MAX_TERMS(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_trunc (out_trunc)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle cycles carry junk data/last to confirm they are ignored while !in_valid.
    task automatic send(input logic [WIDTH-1:0] d, input logic last, input int gap);
        int k;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = WIDTH'($urandom_range(0, 8191));
            in_last  = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        k = 0;
        while (!in_ready && k < 40) begin
            tick();
            k++;
        end
        check("send_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get_result(input string tag, input int es, input int ec, input int et, input int hold);
        int k;
        k = 0;
        while (!out_valid && k < 40) begin
            tick();
            k++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sum"},   32'(out_sum),   32'(es));
        check({tag, "_count"}, 32'(out_count), 32'(ec));
        check({tag, "_trunc"}, 32'(out_trunc), 32'(et));
        repeat (hold) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drop"},  32'(out_valid), 32'd0);
        check({tag, "_ready"}, 32'(in_ready),  32'd1);
    endtask

    initial begin
        int len;
        int exp_sum;
        logic [WIDTH-1:0] d;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready),  32'd1);
        check("rst_sum",   32'(out_sum),   32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_trunc", 32'(out_trunc), 32'd0);
        rst = 1'b0;
        tick();

        // Mid-burst async reset discards the partial burst
        send(13'd100, 1'b0, 0);
        send(13'd200, 1'b0, 0);
        send(13'd300, 1'b0, 0);
        #3 rst = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready),  32'd1);
        tick();
        rst = 1'b0;
        send(13'd5, 1'b1, 0);
        get_result("single", 5, 1, 0, 0);

        // Burst 1..4 with latency check
        send(13'd1, 1'b0, 0);
        send(13'd2, 1'b0, 0);
        send(13'd3, 1'b0, 0);
        send(13'd4, 1'b1, 0);
        check("lat_n1", 32'(out_valid), 32'd0);
        check("lat_n1_ready", 32'(in_ready), 32'd0);
        tick();
        check("lat_n2", 32'(out_valid), 32'd1);
        get_result("b1234", 10, 4, 0, 0);

        // Max-value burst closed normally on beat 16
        for (int i = 0; i < 16; i++) send(13'd8191, i == 15, 0);
        get_result("maxval", 131056, 16, 0, 0);

        // 18 beats without last: forced close at 16, excess beats stall and start next burst
        for (int i = 0; i < 16; i++) send(13'd1, 1'b0, 0);
        in_valid = 1'b1;
        in_data  = 13'd1;
        in_last  = 1'b0;
        check("stall_0", 32'(in_ready), 32'd0);
        tick();
        check("stall_1", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        get_result("trunc", 16, 16, 1, 0);
        send(13'd1, 1'b0, 0);
        send(13'd1, 1'b1, 0);
        get_result("excess", 2, 2, 0, 0);

        // Back-pressure: outputs stable, in_ready low while out_ready is held off
        send(13'd7, 1'b0, 0);
        send(13'd9, 1'b1, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_sum",   32'(out_sum),   32'd16);
            check("bp_count", 32'(out_count), 32'd2);
            check("bp_ready", 32'(in_ready),  32'd0);
            tick();
        end
        get_result("bp", 16, 2, 0, 0);

        // Async reset while a result is pending
        send(13'd3, 1'b1, 0);
        tick();
        check("outrst_pre", 32'(out_valid), 32'd1);
        #3 rst = 1'b1;
        #1;
        check("outrst_valid", 32'(out_valid), 32'd0);
        check("outrst_sum",   32'(out_sum),   32'd0);
        check("outrst_ready", 32'(in_ready),  32'd1);
        tick();
        rst = 1'b0;
        send(13'd6, 1'b0, 0);
        send(13'd8, 1'b1, 0);
        get_result("postrst", 14, 2, 0, 0);

        // Random bursts with idle gaps and random consumer delay
        for (int b = 0; b < 1000; b++) begin
            len     = $urandom_range(1, 16);
            exp_sum = 0;
            for (int i = 0; i < len; i++) begin
                d = WIDTH'($urandom_range(0, 8191));
                exp_sum += int'(d);
                send(d, i == len - 1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
            end
            get_result("rnd", exp_sum, len, 0, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
